// File: rtl/omi_axi_pkg.sv
// Shared types and AXI constants for the OMI-to-AXI4 bridge.
package omi_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_WACC,
        ST_B
    } state_e;

    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // AXI size encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/omi_axi_bridge.sv
// OMI slave to AXI4 master bridge: one burst outstanding, write data pulled
// from the requester one beat at a time through the o_rdy handshake.
module omi_axi_bridge
    import omi_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic                    i_wen,
    input  logic [DATA_WIDTH/8-1:0] i_ben,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [7:0]              i_len,
    output logic                    o_rdy,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_err,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = axi_size(DATA_WIDTH);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              len_q, len_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0]       ben_q, ben_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    rerr_q, rerr_d;
    logic                    rdy_q, rdy_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   odata_q, odata_d;
    logic                    last_beat;

    assign last_beat = (cnt_q == len_q);

    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        ben_d   = ben_q;
        data_d  = data_q;
        rerr_d  = rerr_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        odata_d = odata_q;

        case (state_q)
            ST_IDLE: if (i_req) state_d = ST_ACC;
            ST_ACC: begin
                addr_d  = i_addr;
                ben_d   = i_ben;
                len_d   = i_len;
                data_d  = i_data;
                cnt_d   = '0;
                rerr_d  = 1'b0;
                state_d = i_wen ? ST_AW : ST_AR;
            end
            ST_AR: if (m_axi_arready) state_d = ST_R;
            ST_R: begin
                if (m_axi_rvalid) begin
                    valid_d = 1'b1;
                    odata_d = m_axi_rdata;
                    cnt_d   = cnt_q + 8'd1;
                    if (m_axi_rresp != OKAY) rerr_d = 1'b1;
                    // Errors seen on earlier beats are reported with the last one.
                    if (m_axi_rlast) begin
                        err_d   = rerr_q || (m_axi_rresp != OKAY) || !last_beat;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_AW: if (m_axi_awready) state_d = ST_W;
            ST_W: begin
                if (m_axi_wready) begin
                    if (last_beat) begin
                        state_d = ST_B;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_WACC;
                    end
                end
            end
            ST_WACC: begin
                data_d  = i_data;
                state_d = ST_W;
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    valid_d = 1'b1;
                    err_d   = (m_axi_bresp != OKAY);
                    odata_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered o_rdy: high exactly while the state register holds ACC/WACC.
        rdy_d = (state_d == ST_ACC) || (state_d == ST_WACC);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    // NOTE: the burst data/address registers are reset too, since they drive
    // AXI outputs directly and must read zero while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            ben_q   <= '0;
            data_q  <= '0;
            rerr_q  <= 1'b0;
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            ben_q   <= ben_d;
            data_q  <= data_d;
            rerr_q  <= rerr_d;
            rdy_q   <= rdy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            odata_q <= odata_d;
        end
    end

    assign o_rdy   = rdy_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_data  = odata_q;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = INCR;
    assign m_axi_arvalid = (state_q == ST_AR);
    assign m_axi_rready  = (state_q == ST_R);

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = INCR;
    assign m_axi_awvalid = (state_q == ST_AW);

    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = ben_q;
    assign m_axi_wvalid  = (state_q == ST_W);
    assign m_axi_wlast   = (state_q == ST_W) && last_beat;
    assign m_axi_bready  = (state_q == ST_B);

endmodule

// File: tb/tb_omi_axi_bridge.sv
// Directed scoreboard bench for omi_axi_bridge with a behavioural AXI slave.
module tb_omi_axi_bridge;
    import omi_axi_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, i_wen;
    logic [9:0]  i_addr;
    logic [3:0]  i_ben;
    logic [31:0] i_data;
    logic [7:0]  i_len;
    logic        o_rdy, o_valid, o_err;
    logic [31:0] o_data;
    logic [9:0]  m_axi_araddr, m_axi_awaddr;
    logic [7:0]  m_axi_arlen, m_axi_awlen;
    logic [2:0]  m_axi_arsize, m_axi_awsize;
    logic [1:0]  m_axi_arburst, m_axi_awburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    int          n_vec = 0;
    int          n_miss = 0;
    int          rdy_total = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] wr_data [8];
    logic [31:0] rd_data [8];
    logic [1:0]  rd_resp [8];

    omi_axi_bridge dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_wen(i_wen), .i_ben(i_ben),
        .i_data(i_data), .i_len(i_len),
        .o_rdy(o_rdy), .o_valid(o_valid), .o_data(o_data), .o_err(o_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every o_valid pulse consumes one expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (o_rdy) rdy_total++;
            if (o_err && !o_valid) check("err_unqualified", 64'(o_valid), 64'd1);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("o_data", 64'(o_data), 64'(mon_e.data));
                    check("o_err", 64'(o_err), 64'(mon_e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic clear_axi_inputs();
        m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
        m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bresp = '0; m_axi_bvalid = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({o_rdy, o_valid, o_err, m_axi_arvalid, m_axi_rready,
                                  m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}), 64'd0);
        check({tag, "_o_data"}, 64'(o_data), 64'd0);
        check({tag, "_addr"}, 64'({m_axi_araddr, m_axi_awaddr}), 64'd0);
        check({tag, "_len"}, 64'({m_axi_arlen, m_axi_awlen}), 64'd0);
        check({tag, "_wdata"}, 64'({m_axi_wdata, m_axi_wstrb}), 64'd0);
    endtask

    // Requester: holds each write beat on i_data until its o_rdy cycle ends.
    task automatic omi_drive(input logic wen, input logic [9:0] addr, input logic [7:0] len,
                             input logic [3:0] ben, input int exp_rdy);
        int seen = 0;
        int cyc = 0;
        @(negedge clk);
        i_req = 1; i_wen = wen; i_addr = addr; i_len = len; i_ben = ben; i_data = wr_data[0];
        while (seen < exp_rdy && cyc < 100) begin
            @(negedge clk);
            cyc++;
            i_data = wr_data[seen];
            if (o_rdy) begin
                seen++;
                i_req = 0;
            end
        end
        i_req = 0;
        check("rdy_pulses_seen", 64'(seen), 64'(exp_rdy));
    endtask

    task automatic axi_read_slave(input logic [9:0] addr, input logic [7:0] len,
                                  input int ar_delay, input int nbeats);
        int cyc = 0;
        do begin @(negedge clk); cyc++; end while (!m_axi_arvalid && cyc < 50);
        if (!m_axi_arvalid) begin
            check("ar_timeout", 64'd0, 64'd1);
            return;
        end
        check("araddr", 64'(m_axi_araddr), 64'(addr));
        check("arlen", 64'(m_axi_arlen), 64'(len));
        check("arsize_burst", 64'({m_axi_arsize, m_axi_arburst}), 64'({3'd2, 2'b01}));
        for (int d = 0; d < ar_delay; d++) begin
            @(negedge clk);
            check("arvalid_hold", 64'({m_axi_arvalid, m_axi_araddr}), 64'({1'b1, addr}));
        end
        m_axi_arready = 1;
        @(negedge clk);
        m_axi_arready = 0;
        for (int i = 0; i < nbeats; i++) begin
            check("rready", 64'(m_axi_rready), 64'd1);
            m_axi_rvalid = 1;
            m_axi_rdata  = rd_data[i];
            m_axi_rresp  = rd_resp[i];
            m_axi_rlast  = (i == nbeats - 1);
            @(negedge clk);
        end
        m_axi_rvalid = 0;
        m_axi_rlast  = 0;
    endtask

    task automatic axi_write_slave(input logic [9:0] addr, input logic [7:0] len,
                                   input logic [3:0] ben, input logic [1:0] bresp);
        int cyc = 0;
        do begin @(negedge clk); cyc++; end while (!m_axi_awvalid && cyc < 50);
        if (!m_axi_awvalid) begin
            check("aw_timeout", 64'd0, 64'd1);
            return;
        end
        check("awaddr", 64'(m_axi_awaddr), 64'(addr));
        check("awlen", 64'(m_axi_awlen), 64'(len));
        check("awsize_burst", 64'({m_axi_awsize, m_axi_awburst}), 64'({3'd2, 2'b01}));
        m_axi_awready = 1;
        @(negedge clk);
        m_axi_awready = 0;
        for (int k = 0; k <= int'(len); k++) begin
            cyc = 0;
            while (!m_axi_wvalid && cyc < 50) begin @(negedge clk); cyc++; end
            if (!m_axi_wvalid) begin
                check("w_timeout", 64'd0, 64'd1);
                return;
            end
            check("wdata", 64'(m_axi_wdata), 64'(wr_data[k]));
            check("wstrb", 64'(m_axi_wstrb), 64'(ben));
            check("wlast", 64'(m_axi_wlast), 64'(k == int'(len)));
            m_axi_wready = 1;
            @(negedge clk);
            m_axi_wready = 0;
        end
        check("bready", 64'(m_axi_bready), 64'd1);
        m_axi_bvalid = 1;
        m_axi_bresp  = bresp;
        @(negedge clk);
        m_axi_bvalid = 0;
        m_axi_bresp  = OKAY;
    endtask

    task automatic drain(input int r0, input int exp_rdy);
        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("rdy_total", 64'(rdy_total - r0), 64'(exp_rdy));
        exp_q.delete();
    endtask

    task automatic run_read(input logic [9:0] addr, input logic [7:0] len, input int ar_delay,
                            input int nbeats, input logic last_err);
        int r0 = rdy_total;
        for (int i = 0; i < nbeats; i++)
            exp_q.push_back('{data: rd_data[i], err: (i == nbeats - 1) ? last_err : 1'b0});
        fork
            omi_drive(1'b0, addr, len, 4'hF, 1);
            axi_read_slave(addr, len, ar_delay, nbeats);
        join
        drain(r0, 1);
    endtask

    task automatic run_write(input logic [9:0] addr, input logic [7:0] len, input logic [3:0] ben,
                             input logic [1:0] bresp, input logic exp_err);
        int r0 = rdy_total;
        exp_q.push_back('{data: 32'h0, err: exp_err});
        fork
            omi_drive(1'b1, addr, len, ben, int'(len) + 1);
            axi_write_slave(addr, len, ben, bresp);
        join
        drain(r0, int'(len) + 1);
    endtask

    initial begin
        int  cyc, seen, wb;
        bit  hit;
        reset_n = 0;
        i_req = 0; i_wen = 0; i_addr = '0; i_ben = '0; i_data = '0; i_len = '0;
        clear_axi_inputs();
        for (int i = 0; i < 8; i++) begin wr_data[i] = '0; rd_data[i] = '0; rd_resp[i] = OKAY; end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1;
        @(negedge clk);
        check_all_zero("idle");

        rd_data[0] = 32'hDEADBEEF;
        run_read(10'h040, 8'd0, 0, 1, 1'b0);

        wr_data[0] = 32'h11; wr_data[1] = 32'h22; wr_data[2] = 32'h33;
        run_write(10'h080, 8'd2, 4'hF, OKAY, 1'b0);

        rd_data[0] = 32'hA1A1A1A1; rd_resp[0] = OKAY;
        rd_data[1] = 32'hB2B2B2B2; rd_resp[1] = SLVERR;
        run_read(10'h100, 8'd1, 5, 2, 1'b1);

        rd_data[0] = 32'hC3C3C3C3; rd_resp[0] = OKAY;
        rd_data[1] = 32'hD4D4D4D4; rd_resp[1] = OKAY;
        run_read(10'h180, 8'd2, 0, 2, 1'b1);

        wr_data[0] = 32'hCAFEF00D;
        run_write(10'h3F0, 8'd0, 4'h3, SLVERR, 1'b1);

        // Abandon a write burst while its second beat is on the W channel.
        wr_data[0] = 32'h5A; wr_data[1] = 32'h6B; wr_data[2] = 32'h7C;
        cyc = 0; seen = 0; wb = 0; hit = 0;
        @(negedge clk);
        i_req = 1; i_wen = 1; i_addr = 10'h200; i_len = 8'd2; i_ben = 4'hF; i_data = wr_data[0];
        while (!hit && cyc < 60) begin
            @(negedge clk);
            cyc++;
            i_data = wr_data[seen];
            if (o_rdy) begin seen++; i_req = 0; end
            m_axi_awready = m_axi_awvalid;
            if (m_axi_wvalid && wb == 1) begin
                hit = 1;
            end else begin
                m_axi_wready = m_axi_wvalid;
                if (m_axi_wvalid) wb++;
            end
        end
        check("reached_w_beat1", 64'(hit), 64'd1);
        check("w_beat1_data", 64'({m_axi_wdata, m_axi_wlast}), 64'({32'h6B, 1'b0}));
        #2 reset_n = 0;
        #1 check_all_zero("midburst_reset");
        i_req = 0;
        clear_axi_inputs();
        repeat (2) @(negedge clk);
        check("reset_held_quiet", 64'({o_valid, o_rdy}), 64'd0);
        reset_n = 1;

        for (int i = 0; i < 4; i++) begin
            rd_data[i] = 32'h1000_0000 + 32'(i);
            rd_resp[i] = OKAY;
        end
        run_read(10'h0C0, 8'd3, 1, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
